// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC register, instruction-memory request, one-entry skid buffer
// and the IF/ID pipeline register feeding decode.
module if_stage_fetch #(
  parameter int unsigned              ADDR_WIDTH  = 32,
  parameter int unsigned              INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC    = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_addr,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ready,
  output logic [ADDR_WIDTH-1:0]  if_id_pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic                   if_id_valid
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  skid_pc_q, skid_pc_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_WIDTH-1:0]  if_id_pc_q, if_id_pc_d;
  logic [INSTR_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
  logic                   if_id_valid_q, if_id_valid_d;
  logic [ADDR_WIDTH-1:0]  pc_plus4_s;

  // Wraps modulo 2^ADDR_WIDTH by construction.
  assign pc_plus4_s = pc_q + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == FETCH) & ~rst;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

  // Next-state selection; priority branch_taken > freeze > imem_ready (rst handled in the flops).
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if (branch_taken) begin
      pc_d          = branch_addr;
      if_id_pc_d    = '0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      skid_pc_d     = '0;
      skid_instr_d  = NOP_INSTR;
      state_d       = FETCH;
    end else if (state_q == HOLD) begin
      if (!freeze) begin
        // pc already points past the skidded instruction, so it stays put.
        if_id_pc_d    = skid_pc_q;
        if_id_instr_d = skid_instr_q;
        if_id_valid_d = 1'b1;
        skid_pc_d     = '0;
        skid_instr_d  = NOP_INSTR;
        state_d       = FETCH;
      end else begin
        state_d = HOLD;
      end
    end else if (freeze) begin
      if (imem_ready) begin
        skid_pc_d    = pc_plus4_s;
        skid_instr_d = imem_rdata;
        pc_d         = pc_plus4_s;
        state_d      = HOLD;
      end else begin
        state_d = FETCH;
      end
    end else if (imem_ready) begin
      if_id_pc_d    = pc_plus4_s;
      if_id_instr_d = imem_rdata;
      if_id_valid_d = 1'b1;
      pc_d          = pc_plus4_s;
    end else begin
      if_id_pc_d    = pc_plus4_s;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end
  end

  // State, PC, skid and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      skid_pc_q     <= '0;
      skid_instr_q  <= NOP_INSTR;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Self-checking bench for if_stage_fetch: vector table with a scoreboard queue for IF/ID,
// plus a second instance with RESET_PC near the top of the address space for wrap-around.
module tb_if_stage_fetch;

  logic        clk;
  logic        rst, freeze, branch_taken, imem_ready;
  logic [31:0] branch_addr, imem_addr, imem_rdata, if_id_pc, if_id_instr;
  logic        imem_req, if_id_valid;

  logic        rst2;
  logic [31:0] imem_addr2, imem_rdata2, if_id_pc2, if_id_instr2;
  logic        imem_req2, if_id_valid2;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'hE3A0_0001;
      32'h0000_0004: mem_word = 32'hE3A0_1002;
      default:       mem_word = {a[15:0] ^ 16'hA5A5, a[15:0]};
    endcase
  endfunction

  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rdata2 = mem_word(imem_addr2);

  if_stage_fetch dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  if_stage_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .freeze(1'b0), .branch_taken(1'b0),
    .branch_addr(32'h0000_0000), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .imem_ready(1'b1), .if_id_pc(if_id_pc2),
    .if_id_instr(if_id_instr2), .if_id_valid(if_id_valid2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst, frz, br;
    logic [31:0] badr;
    logic        rdy;
    logic        exp_req;
    logic        chk_addr;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  vec_t vecs[21];
  exp_t sbq[$];

  function automatic vec_t mk(input logic r, input logic f, input logic b, input logic [31:0] ba,
                              input logic rd, input logic rq, input logic ca, input logic [31:0] ea,
                              input logic [31:0] ep, input logic [31:0] ei, input logic ev);
    vec_t v;
    v.rst = r; v.frz = f; v.br = b; v.badr = ba; v.rdy = rd;
    v.exp_req = rq; v.chk_addr = ca; v.exp_addr = ea;
    v.exp_pc = ep; v.exp_instr = ei; v.exp_valid = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    // rst frz br badr rdy | req chk_addr addr | if_id pc instr valid (after the edge)
    vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0,  1'b1, 1'b0,1'b0,32'h0,   32'h0,   32'h0,        1'b0);
    vecs[1]  = mk(1'b1,1'b0,1'b0,32'h0,  1'b1, 1'b0,1'b1,32'h0,   32'h0,   32'h0,        1'b0);
    vecs[2]  = mk(1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,1'b1,32'h0,   32'h4,   32'hE3A00001, 1'b1);
    vecs[3]  = mk(1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,1'b1,32'h4,   32'h8,   32'hE3A01002, 1'b1);
    vecs[4]  = mk(1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,1'b1,32'h8,   32'hC,   32'h0,        1'b0);
    vecs[5]  = mk(1'b0,1'b0,1'b0,32'h0,  1'b0, 1'b1,1'b1,32'h8,   32'hC,   32'h0,        1'b0);
    vecs[6]  = mk(1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,1'b1,32'h8,   32'hC,   32'hA5AD0008, 1'b1);
    vecs[7]  = mk(1'b0,1'b1,1'b0,32'h0,  1'b1, 1'b1,1'b1,32'hC,   32'hC,   32'hA5AD0008, 1'b1);
    vecs[8]  = mk(1'b0,1'b1,1'b0,32'h0,  1'b1, 1'b0,1'b1,32'h10,  32'hC,   32'hA5AD0008, 1'b1);
    vecs[9]  = mk(1'b0,1'b1,1'b0,32'h0,  1'b0, 1'b0,1'b1,32'h10,  32'hC,   32'hA5AD0008, 1'b1);
    vecs[10] = mk(1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b0,1'b1,32'h10,  32'h10,  32'hA5A9000C, 1'b1);
    vecs[11] = mk(1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,1'b1,32'h10,  32'h14,  32'hA5B50010, 1'b1);
    vecs[12] = mk(1'b0,1'b1,1'b0,32'h0,  1'b0, 1'b1,1'b1,32'h14,  32'h14,  32'hA5B50010, 1'b1);
    vecs[13] = mk(1'b0,1'b1,1'b0,32'h0,  1'b1, 1'b1,1'b1,32'h14,  32'h14,  32'hA5B50010, 1'b1);
    vecs[14] = mk(1'b0,1'b1,1'b1,32'h100,1'b1, 1'b0,1'b1,32'h18,  32'h0,   32'h0,        1'b0);
    vecs[15] = mk(1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,1'b1,32'h100, 32'h104, 32'hA4A50100, 1'b1);
    vecs[16] = mk(1'b0,1'b0,1'b1,32'h200,1'b1, 1'b1,1'b1,32'h104, 32'h0,   32'h0,        1'b0);
    vecs[17] = mk(1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,1'b1,32'h200, 32'h204, 32'hA7A50200, 1'b1);
    vecs[18] = mk(1'b0,1'b1,1'b0,32'h0,  1'b1, 1'b1,1'b1,32'h204, 32'h204, 32'hA7A50200, 1'b1);
    vecs[19] = mk(1'b1,1'b1,1'b0,32'h0,  1'b1, 1'b0,1'b1,32'h208, 32'h0,   32'h0,        1'b0);
    vecs[20] = mk(1'b0,1'b0,1'b0,32'h0,  1'b1, 1'b1,1'b1,32'h0,   32'h4,   32'hE3A00001, 1'b1);

    rst2 = 1'b1;
    for (int i = 0; i < 21; i++) begin
      rst = vecs[i].rst; freeze = vecs[i].frz; branch_taken = vecs[i].br;
      branch_addr = vecs[i].badr; imem_ready = vecs[i].rdy;
      #2;
      chk($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].chk_addr) chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
      e.pc = vecs[i].exp_pc; e.instr = vecs[i].exp_instr; e.valid = vecs[i].exp_valid;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk($sformatf("v%0d if_id_pc", i), if_id_pc, e.pc);
      chk($sformatf("v%0d if_id_instr", i), if_id_instr, e.instr);
      chk($sformatf("v%0d if_id_valid", i), {31'd0, if_id_valid}, {31'd0, e.valid});
    end

    // Wrap-around: PC 0xFFFFFFFC advances to 0x0.
    chk("wrap reset req", {31'd0, imem_req2}, 32'd0);
    chk("wrap reset addr", imem_addr2, 32'hFFFF_FFFC);
    chk("wrap reset valid", {31'd0, if_id_valid2}, 32'd0);
    rst2 = 1'b0;
    #1;
    chk("wrap req", {31'd0, imem_req2}, 32'd1);
    @(posedge clk);
    #1;
    chk("wrap if_id_pc", if_id_pc2, 32'h0);
    chk("wrap if_id_instr", if_id_instr2, 32'h5A59FFFC);
    chk("wrap if_id_valid", {31'd0, if_id_valid2}, 32'd1);
    chk("wrap next addr", imem_addr2, 32'h0);
    @(posedge clk);
    #1;
    chk("wrap+1 if_id_pc", if_id_pc2, 32'h4);
    chk("wrap+1 if_id_instr", if_id_instr2, 32'hE3A00001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
